// File: rtl/sram_lane_model_pkg.sv
// Shared types and helpers for the SRAM lane model: latency limit,
// byte-lane merge helper and the read-pipeline entry layout.
package sram_lane_model_pkg;

    localparam int MAX_RD_LAT = 7;
    localparam int MAX_LANES  = 8;
    localparam int MAX_DW     = 8 * MAX_LANES;

    // One read-pipeline slot: valid flag plus read word (low DW bits used).
    typedef struct packed {
        logic              valid;
        logic [MAX_DW-1:0] data;
    } rd_entry_t;

    // Replace every byte lane whose active-low enable is 0 with the new byte.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0]    old_word,
        input logic [MAX_DW-1:0]    new_word,
        input logic [MAX_LANES-1:0] be_n
    );
        logic [MAX_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (be_n[i] == 1'b0) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: LAT register stages of {valid, data}. The data
// field only advances with a valid entry, so the output keeps the last
// delivered word while nothing valid is flowing. LAT=0 is a pass-through
// with a small hold register for the same hold behaviour.
module sram_rd_pipe #(
    parameter int W   = 17,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] in_entry,
    output logic [W-1:0] out_entry
);

    generate
        if (LAT == 0) begin : g_bypass
            logic [W-2:0] hold_r;

            // Remember the last delivered word so it persists when no read is valid
            always_ff @(posedge clk) begin
                if (clr) begin
                    hold_r <= '0;
                end else if (in_entry[W-1]) begin
                    hold_r <= in_entry[W-2:0];
                end
            end

            // Combinational pass-through of the current sample, else the held word
            always_comb begin
                if (in_entry[W-1]) begin
                    out_entry = in_entry;
                end else begin
                    out_entry = {1'b0, hold_r};
                end
            end
        end else begin : g_stages
            logic [W-1:0] stage_r [LAT];

            // Shift valid every cycle; move data only alongside a valid flag
            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int i = 0; i < LAT; i++) begin
                        stage_r[i] <= '0;
                    end
                end else begin
                    stage_r[0][W-1] <= in_entry[W-1];
                    if (in_entry[W-1]) begin
                        stage_r[0][W-2:0] <= in_entry[W-2:0];
                    end
                    for (int i = 1; i < LAT; i++) begin
                        stage_r[i][W-1] <= stage_r[i-1][W-1];
                        if (stage_r[i-1][W-1]) begin
                            stage_r[i][W-2:0] <= stage_r[i-1][W-2:0];
                        end
                    end
                end
            end

            assign out_entry = stage_r[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/sram_lane_model.sv
// Clocked model of an external asynchronous SRAM with N byte lanes,
// programmable read latency, write-strobe edge commit, collision and
// range error flags, and access counters.
module sram_lane_model
    import sram_lane_model_pkg::*;
#(
    parameter int          LANES  = 2,
    parameter int          AW     = 18,
    parameter int          DEPTH  = 8192,
    parameter int          RD_LAT = 1,
    parameter logic [7:0]  FILL   = 8'hFF,
    parameter int          CW     = 16,
    localparam int         DW     = 8 * LANES
) (
    input  logic             RCLK,
    input  logic             RST,
    input  logic             CE_N,
    input  logic             OE_N,
    input  logic             WE_N,
    input  logic [LANES-1:0] BE_N,
    input  logic [AW-1:0]    ADDR,
    input  logic [DW-1:0]    WDATA,
    output logic [DW-1:0]    RDATA,
    output logic             RVALID,
    output logic             DOE,
    output logic             ERR_COLL,
    output logic             ERR_RANGE,
    output logic [CW-1:0]    WR_CNT,
    output logic [CW-1:0]    RD_CNT
);

    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMPW    = (AW > 32) ? AW : 32;
    localparam int LAT_EFF = (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT;

    logic [DW-1:0]    mem_r [DEPTH];

    logic             we_q_r;
    logic [AW-1:0]    wr_addr_r;
    logic [DW-1:0]    wr_data_r;
    logic [LANES-1:0] wr_be_n_r;
    logic [CW-1:0]    wr_cnt_r;
    logic [CW-1:0]    rd_cnt_r;
    logic             err_coll_r;
    logic             err_range_r;

    logic             commit_s;
    logic             rd_s;
    logic             coll_s;
    logic             wr_cap_s;
    logic             fwd_s;
    logic             wr_in_range_s;
    logic             rd_in_range_s;
    logic [CMPW-1:0]  wr_addr_ext_s;
    logic [CMPW-1:0]  rd_addr_ext_s;
    logic [DW-1:0]    wr_old_s;
    logic [DW-1:0]    wr_merged_s;
    logic [DW-1:0]    rd_word_s;
    rd_entry_t        sample_s;
    logic [DW:0]      pipe_out_s;

    // Decode bus phases, range checks and the read word (with commit forwarding)
    always_comb begin
        commit_s      = WE_N & ~we_q_r;
        rd_s          = ~CE_N & ~OE_N & WE_N;
        coll_s        = ~CE_N & ~OE_N & ~WE_N;
        wr_cap_s      = ~CE_N & ~WE_N;
        wr_addr_ext_s = CMPW'(wr_addr_r);
        rd_addr_ext_s = CMPW'(ADDR);
        wr_in_range_s = (wr_addr_ext_s < CMPW'(DEPTH));
        rd_in_range_s = (rd_addr_ext_s < CMPW'(DEPTH));
        wr_old_s      = mem_r[wr_addr_ext_s[IW-1:0]];
        wr_merged_s   = DW'(lane_merge(MAX_DW'(wr_old_s), MAX_DW'(wr_data_r),
                                       MAX_LANES'(wr_be_n_r)));
        fwd_s         = commit_s & wr_in_range_s & (wr_addr_ext_s == rd_addr_ext_s);
        if (!rd_in_range_s) begin
            rd_word_s = {LANES{FILL}};
        end else if (fwd_s) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = mem_r[rd_addr_ext_s[IW-1:0]];
        end
        sample_s.valid = rd_s;
        sample_s.data  = MAX_DW'(rd_word_s);
    end

    // Memory array takes committed writes only; contents survive reset
    always_ff @(posedge RCLK) begin
        if (!RST && commit_s && wr_in_range_s) begin
            mem_r[wr_addr_ext_s[IW-1:0]] <= wr_merged_s;
        end
    end

    // Strobe history, write latch, counters and sticky error flags
    always_ff @(posedge RCLK) begin
        if (RST) begin
            we_q_r      <= 1'b1;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            wr_be_n_r   <= '1;
            wr_cnt_r    <= '0;
            rd_cnt_r    <= '0;
            err_coll_r  <= 1'b0;
            err_range_r <= 1'b0;
        end else begin
            we_q_r <= WE_N;
            if (wr_cap_s) begin
                wr_addr_r <= ADDR;
                wr_data_r <= WDATA;
                wr_be_n_r <= BE_N;
            end
            if (commit_s) begin
                wr_cnt_r <= wr_cnt_r + CW'(1'b1);
            end
            if (rd_s) begin
                rd_cnt_r <= rd_cnt_r + CW'(1'b1);
            end
            if (coll_s) begin
                err_coll_r <= 1'b1;
            end
            if ((commit_s && !wr_in_range_s) || (rd_s && !rd_in_range_s)) begin
                err_range_r <= 1'b1;
            end
        end
    end

    sram_rd_pipe #(
        .W   (DW + 1),
        .LAT (LAT_EFF)
    ) u_rd_pipe (
        .clk       (RCLK),
        .clr       (RST),
        .in_entry  ({sample_s.valid, DW'(sample_s.data)}),
        .out_entry (pipe_out_s)
    );

    assign RDATA     = pipe_out_s[DW-1:0];
    assign RVALID    = pipe_out_s[DW];
    assign DOE       = pipe_out_s[DW] & rd_s;
    assign ERR_COLL  = err_coll_r;
    assign ERR_RANGE = err_range_r;
    assign WR_CNT    = wr_cnt_r;
    assign RD_CNT    = rd_cnt_r;

endmodule

// File: tb/tb_sram_lane_model.sv
// Bench for sram_lane_model: three instances (read latency 0, 1, 3) share
// one stimulus stream. A bench-side memory model predicts every read and
// pushes it into a per-instance queue with its due cycle; outputs are
// checked every cycle, plus table rows and hand-written corner sequences.
module tb_sram_lane_model;

    logic        clk;
    logic        rst;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [1:0]  be_n;
    logic [17:0] addr;
    logic [15:0] wdata;

    logic [15:0] rdata_a  [3];
    logic        rvalid_a [3];
    logic        doe_a    [3];
    logic        ecoll_a  [3];
    logic        erange_a [3];
    logic [15:0] wrc_a    [3];
    logic [15:0] rdc_a    [3];

    sram_lane_model #(.LANES(2), .AW(18), .DEPTH(8192), .RD_LAT(0), .FILL(8'hFF), .CW(16)) u_dut0 (
        .RCLK(clk), .RST(rst), .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n), .BE_N(be_n),
        .ADDR(addr), .WDATA(wdata), .RDATA(rdata_a[0]), .RVALID(rvalid_a[0]), .DOE(doe_a[0]),
        .ERR_COLL(ecoll_a[0]), .ERR_RANGE(erange_a[0]), .WR_CNT(wrc_a[0]), .RD_CNT(rdc_a[0]));

    sram_lane_model #(.LANES(2), .AW(18), .DEPTH(8192), .RD_LAT(1), .FILL(8'hFF), .CW(16)) u_dut1 (
        .RCLK(clk), .RST(rst), .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n), .BE_N(be_n),
        .ADDR(addr), .WDATA(wdata), .RDATA(rdata_a[1]), .RVALID(rvalid_a[1]), .DOE(doe_a[1]),
        .ERR_COLL(ecoll_a[1]), .ERR_RANGE(erange_a[1]), .WR_CNT(wrc_a[1]), .RD_CNT(rdc_a[1]));

    sram_lane_model #(.LANES(2), .AW(18), .DEPTH(8192), .RD_LAT(3), .FILL(8'hFF), .CW(16)) u_dut3 (
        .RCLK(clk), .RST(rst), .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n), .BE_N(be_n),
        .ADDR(addr), .WDATA(wdata), .RDATA(rdata_a[2]), .RVALID(rvalid_a[2]), .DOE(doe_a[2]),
        .ERR_COLL(ecoll_a[2]), .ERR_RANGE(erange_a[2]), .WR_CNT(wrc_a[2]), .RD_CNT(rdc_a[2]));

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        is_wr;
        logic [17:0] addr;
        logic [15:0] data;
        logic [1:0]  be_n;
        int          hold;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;

    exp_t        sbq [3][$];
    logic [15:0] mem_m [int];
    logic [15:0] last_rd [3];
    vec_t        vecs [16];

    int          n_chk;
    int          n_fail;
    int          cyc_n;
    bit          chk_en;
    logic        we_q_m;
    logic [17:0] lat_addr_m;
    logic [15:0] lat_data_m;
    logic [1:0]  lat_be_m;
    logic [15:0] wr_cnt_m;
    logic [15:0] rd_cnt_m;
    logic        err_coll_m;
    logic        err_range_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        case (k)
            0:       lat_of = 0;
            1:       lat_of = 1;
            default: lat_of = 3;
        endcase
    endfunction

    function automatic logic [15:0] merge_m(input logic [15:0] o, input logic [15:0] n,
                                            input logic [1:0] b);
        merge_m = o;
        if (!b[0]) merge_m[7:0]  = n[7:0];
        if (!b[1]) merge_m[15:8] = n[15:8];
    endfunction

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        if (mem_m.exists(int'(a))) mem_rd = mem_m[int'(a)];
        else mem_rd = 16'h0000;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp_val);
        n_chk++;
        if (act !== exp_val) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc_n, act, exp_val);
        end
    endtask

    // One clock cycle: model the edge, check every instance, then advance.
    task automatic step();
        logic        commit_m, rd_m, coll_m, wr_oor, rd_oor, exp_v;
        logic [15:0] rd_word;
        exp_t        e;
        #1;
        commit_m = we_n && !we_q_m;
        rd_m     = !ce_n && !oe_n && we_n;
        coll_m   = !ce_n && !oe_n && !we_n;
        wr_oor   = (lat_addr_m >= 18'd8192);
        rd_oor   = (addr >= 18'd8192);
        if (!rst && commit_m && !wr_oor)
            mem_m[int'(lat_addr_m)] = merge_m(mem_rd(lat_addr_m), lat_data_m, lat_be_m);
        if (!rst && rd_m) begin
            rd_word = rd_oor ? 16'hFFFF : mem_rd(addr);
            for (int k = 0; k < 3; k++) begin
                e.due  = cyc_n + lat_of(k);
                e.data = rd_word;
                sbq[k].push_back(e);
            end
        end
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                exp_v = (sbq[k].size() > 0) && (sbq[k][0].due == cyc_n);
                chk("rvalid", k, 32'(rvalid_a[k]), 32'(exp_v));
                chk("doe", k, 32'(doe_a[k]), 32'(exp_v && rd_m));
                if (exp_v) begin
                    e = sbq[k].pop_front();
                    chk("rdata", k, 32'(rdata_a[k]), 32'(e.data));
                    last_rd[k] = rdata_a[k];
                end
                chk("wr_cnt", k, 32'(wrc_a[k]), 32'(wr_cnt_m));
                chk("rd_cnt", k, 32'(rdc_a[k]), 32'(rd_cnt_m));
                chk("err_coll", k, 32'(ecoll_a[k]), 32'(err_coll_m));
                chk("err_range", k, 32'(erange_a[k]), 32'(err_range_m));
            end
        end
        if (rst) begin
            for (int k = 0; k < 3; k++) sbq[k].delete();
            we_q_m = 1'b1; lat_addr_m = 18'd0; lat_data_m = 16'd0; lat_be_m = 2'b11;
            wr_cnt_m = 16'd0; rd_cnt_m = 16'd0; err_coll_m = 1'b0; err_range_m = 1'b0;
        end else begin
            if (commit_m) begin
                wr_cnt_m = wr_cnt_m + 16'd1;
                if (wr_oor) err_range_m = 1'b1;
            end
            if (rd_m) begin
                rd_cnt_m = rd_cnt_m + 16'd1;
                if (rd_oor) err_range_m = 1'b1;
            end
            if (coll_m) err_coll_m = 1'b1;
            if (!ce_n && !we_n) begin
                lat_addr_m = addr; lat_data_m = wdata; lat_be_m = be_n;
            end
            we_q_m = we_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] b,
                            input int hold);
        ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; addr = a; wdata = d; be_n = b;
        for (int i = 0; i < hold; i++) step();
        idle(2);
    endtask

    task automatic do_read(input logic [17:0] a, input logic [15:0] exp_d);
        for (int k = 0; k < 3; k++) last_rd[k] = ~exp_d;
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = a;
        step();
        idle(4);
        for (int k = 0; k < 3; k++) chk("read_result", k, 32'(last_rd[k]), 32'(exp_d));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 18'd5,    16'hA55A, 2'b00, 3, 16'h0000, 16'd1};
        vecs[1]  = '{1'b0, 18'd5,    16'h0000, 2'b00, 1, 16'hA55A, 16'd1};
        vecs[2]  = '{1'b1, 18'd7,    16'h1234, 2'b00, 1, 16'h0000, 16'd2};
        vecs[3]  = '{1'b1, 18'd7,    16'hFFFF, 2'b10, 1, 16'h0000, 16'd3};
        vecs[4]  = '{1'b0, 18'd7,    16'h0000, 2'b00, 1, 16'h12FF, 16'd3};
        vecs[5]  = '{1'b1, 18'd7,    16'h0000, 2'b11, 1, 16'h0000, 16'd4};
        vecs[6]  = '{1'b0, 18'd7,    16'h0000, 2'b00, 1, 16'h12FF, 16'd4};
        vecs[7]  = '{1'b1, 18'd0,    16'd10,   2'b00, 1, 16'h0000, 16'd5};
        vecs[8]  = '{1'b1, 18'd1,    16'd11,   2'b00, 2, 16'h0000, 16'd6};
        vecs[9]  = '{1'b1, 18'd2,    16'd12,   2'b00, 1, 16'h0000, 16'd7};
        vecs[10] = '{1'b1, 18'd3,    16'd13,   2'b00, 1, 16'h0000, 16'd8};
        vecs[11] = '{1'b1, 18'd808,  16'h0808, 2'b00, 1, 16'h0000, 16'd9};
        vecs[12] = '{1'b1, 18'd9000, 16'hDEAD, 2'b00, 1, 16'h0000, 16'd10};
        vecs[13] = '{1'b0, 18'd808,  16'h0000, 2'b00, 1, 16'h0808, 16'd10};
        vecs[14] = '{1'b0, 18'd8192, 16'h0000, 2'b00, 1, 16'hFFFF, 16'd10};
        vecs[15] = '{1'b1, 18'd40,   16'h1111, 2'b00, 1, 16'h0000, 16'd11};

        n_chk = 0; n_fail = 0; cyc_n = 0; chk_en = 1'b0;
        we_q_m = 1'b1; lat_addr_m = 18'd0; lat_data_m = 16'd0; lat_be_m = 2'b11;
        wr_cnt_m = 16'd0; rd_cnt_m = 16'd0; err_coll_m = 1'b0; err_range_m = 1'b0;
        rst = 1'b1; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        be_n = 2'b11; addr = 18'd0; wdata = 16'd0;

        // Reset state
        step();
        chk_en = 1'b1;
        step();
        for (int k = 0; k < 3; k++) chk("reset_rdata", k, 32'(rdata_a[k]), 32'd0);
        rst = 1'b0;
        idle(1);

        // Table of writes and reads with fixed expected results
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].be_n, vecs[i].hold);
            else do_read(vecs[i].addr, vecs[i].exp_rd);
            for (int k = 0; k < 3; k++) chk("vec_wr_cnt", k, 32'(wrc_a[k]), 32'(vecs[i].exp_wr));
        end
        for (int k = 0; k < 3; k++) chk("range_flag", k, 32'(erange_a[k]), 32'd1);

        // Back-to-back reads of addresses 0..3
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr = 18'(a);
            step();
        end
        idle(5);
        for (int k = 0; k < 3; k++) begin
            chk("b2b_last", k, 32'(last_rd[k]), 32'h000D);
            chk("b2b_rd_cnt", k, 32'(rdc_a[k]), 32'd9);
        end

        // Collision: write latch still captures, commit on release
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0; addr = 18'd20; wdata = 16'hBEEF; be_n = 2'b00;
        step();
        idle(2);
        for (int k = 0; k < 3; k++) chk("coll_flag", k, 32'(ecoll_a[k]), 32'd1);
        do_read(18'd20, 16'hBEEF);

        // Read sampled in the same cycle as the commit sees the new data
        ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; addr = 18'd30; wdata = 16'h5A5A; be_n = 2'b00;
        step();
        oe_n = 1'b0; we_n = 1'b1;
        for (int k = 0; k < 3; k++) last_rd[k] = 16'h0000;
        step();
        idle(4);
        for (int k = 0; k < 3; k++) chk("fwd_data", k, 32'(last_rd[k]), 32'h5A5A);

        // Output enable released before data arrives: RVALID without DOE
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = 18'd5;
        step();
        idle(4);

        // Reset during a held write strobe with reads still in flight
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = 18'd5;
        step(); step(); step();
        oe_n = 1'b1; we_n = 1'b0; addr = 18'd40; wdata = 16'h9999; be_n = 2'b00;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; we_n = 1'b1; ce_n = 1'b1;
        step(); step();
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_wr_cnt", k, 32'(wrc_a[k]), 32'd0);
            chk("post_rst_rd_cnt", k, 32'(rdc_a[k]), 32'd0);
            chk("post_rst_rvalid", k, 32'(rvalid_a[k]), 32'd0);
            chk("post_rst_rdata", k, 32'(rdata_a[k]), 32'd0);
            chk("post_rst_range", k, 32'(erange_a[k]), 32'd0);
        end
        do_read(18'd40, 16'h1111);
        do_read(18'd5, 16'hA55A);
        for (int k = 0; k < 3; k++) begin
            chk("final_rd_cnt", k, 32'(rdc_a[k]), 32'd2);
            chk("final_wr_cnt", k, 32'(wrc_a[k]), 32'd0);
            chk("sb_empty", k, 32'(sbq[k].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_lane_model.md
Name: sram_lane_model

Overview:
- Clocked, parametrised model of an external asynchronous SRAM for the chip-level simulation bench.
- Generalises the fixed 2-lane x 8 Kword memory to N byte lanes, arbitrary depth, and programmable read latency (wait states).
- Adds write-strobe edge detection, bus-collision and out-of-range checking, and access counters.
- Sits between the chip's SRAM pins (control, address, data) and the bench.
- The bench resolves tristating: it drives the pad from RDATA whenever DOE=1.

Parameters:
- LANES, 2, number of byte lanes; data width DW = 8*LANES.
- AW, 18, address port width.
- DEPTH, 8192, implemented words; addresses >= DEPTH are out of range.
- RD_LAT, 1, cycles from read sample to RDATA/RVALID; legal range 0..7.
- FILL, 8'hFF, byte value returned on out-of-range reads.
- CW, 16, width of the access counters.

Ports:
- RCLK  in  1  model clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- CE_N  in  1  chip enable, active low.
- OE_N  in  1  output enable, active low.
- WE_N  in  1  write strobe, active low.
- BE_N  in  LANES  byte-lane enables, active low; lane i maps to data bits [8i+7:8i].
- ADDR  in  AW  word address.
- WDATA  in  DW  data from the chip.
- RDATA  out  DW  read data.
- RVALID  out  1  RDATA is valid this cycle.
- DOE  out  1  model drives the data bus.
- ERR_COLL  out  1  sticky: OE_N and WE_N were low together while CE_N was low.
- ERR_RANGE  out  1  sticky: an access was made with ADDR >= DEPTH.
- WR_CNT  out  CW  number of committed writes, wraps modulo 2^CW.
- RD_CNT  out  CW  number of sampled reads, wraps modulo 2^CW.

Behaviour:
- Reset (RST=1 at an RCLK edge): RDATA=0, RVALID=0, DOE=0, ERR_COLL=0, ERR_RANGE=0, WR_CNT=0, RD_CNT=0.
  - Reset also clears the read pipeline and the write latch, so a write strobe in progress is discarded.
  - Memory contents are not cleared by reset.
- Write phase: every cycle with CE_N=0 and WE_N=0, latch ADDR, WDATA and BE_N.
  - The last sample before WE_N rises is the one committed.
- Write commit: on the first cycle where WE_N=1 and the registered WE_N was 0 (rising strobe), write each lane whose latched BE_N bit is 0 to mem[latched ADDR].
  - The commit is unconditional on CE_N in that cycle; WR_CNT increments by 1.
  - If the latched ADDR >= DEPTH: no memory update, ERR_RANGE set, WR_CNT still increments.
  - WE_N held low for many cycles gives exactly one commit, at release.
- Read sample: a cycle with CE_N=0, OE_N=0, WE_N=1 samples ADDR; RD_CNT increments by 1.
  - Data is taken from memory as it stands after any commit in that same cycle (commit has priority; write-then-read forwarding).
  - An out-of-range read returns FILL in every lane and sets ERR_RANGE.
- Read latency: sampled data and a valid flag pass through RD_LAT register stages.
  - RD_LAT=0: RDATA is combinational from the current sample and RVALID equals the sample condition.
  - Back-to-back samples give one result per cycle; there are no bubbles.
  - RDATA holds its last value when RVALID=0.
- DOE=1 exactly when RVALID=1 and the current CE_N=0, OE_N=0, WE_N=1.
  - If OE_N deasserts before the data arrives, the result is dropped from the bus: DOE=0, but RVALID still pulses.
- Collision: CE_N=0 with OE_N=0 and WE_N=0 sets ERR_COLL.
  - The write latch still captures; no read is sampled; DOE=0.
- Lane ordering: byte lane 0 is the LSB, matching low byte = BE_N[0].
- Out-of-range detection is computed with ADDR zero-extended; AW may exceed $clog2(DEPTH).

Decomposition:
- Package sram_lane_model_pkg:
  - MAX_RD_LAT=7.
  - function lane_merge(old, new, be_n), returning DW bits.
  - Typedef for the read-pipeline entry {valid, data}.
- Sub-module sram_rd_pipe: a parametrised depth-RD_LAT, width-(DW+1) shift register with synchronous clear, bypassed when RD_LAT=0.

Test Plan:
- Write 16'hA55A to addr 5 (BE_N=2'b00, WE_N low 3 cycles), then read addr 5 with RD_LAT=1 -> one commit (WR_CNT=1); RDATA=16'hA55A, RVALID and DOE high exactly 1 cycle after the sample.
- Preload addr 7 = 16'h1234, write 16'hFFFF with BE_N=2'b10 -> read gives 16'h12FF; write 16'h0000 with BE_N=2'b11 -> read unchanged, WR_CNT increments.
- RD_LAT=3, back-to-back reads of addrs 0,1,2,3 holding 10,11,12,13 -> RVALID high for 4 consecutive cycles starting 3 cycles after the first sample, data in order; RD_CNT=4.
- Read addr 8192 (DEPTH=8192) -> RDATA=16'hFFFF, ERR_RANGE=1; a write to 9000 leaves memory unchanged; flag stays set until RST.
- OE_N=0, WE_N=0, CE_N=0 for one cycle -> ERR_COLL=1, DOE=0, no RVALID; the write commits on WE_N release.
- Assert RST for 1 cycle while WE_N is low with the read pipe full -> no commit on release, RVALID=0, counters=0; memory still returns pre-reset contents.
